// File: rtl/dsp_mac_sequencer_pkg.sv
// Shared types and DSP48A1 OPMODE constants for the MAC sequencer.
package dsp_mac_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] OPM_IDLE = 8'h00;  // P holds
    localparam logic [7:0] OPM_LOAD = 8'h01;  // P = M
    localparam logic [7:0] OPM_ACC  = 8'h09;  // P = P + M

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// Control/handshake bundle between a MAC run requester and the sequencer.
interface dsp_mac_sequencer_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             s_valid;
    logic             s_ready;
    logic [7:0]       opmode;
    logic             cep;
    logic             rstp;
    logic             busy;
    logic             done;

    modport master (
        output start, len, abort, s_valid,
        input  s_ready, opmode, cep, rstp, busy, done
    );

    modport slave (
        input  start, len, abort, s_valid,
        output s_ready, opmode, cep, rstp, busy, done
    );
endinterface

// File: rtl/dsp_mac_sequencer_tag_pipe.sv
// Valid/first tag delay line matching the DSP slice latency up to the P stage.
// Advances every cycle (no stall); flush drops everything in flight.
module dsp_tag_pipe #(
    parameter int LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_flush,
    input  logic i_valid,
    input  logic i_first,
    output logic o_tail_valid,
    output logic o_tail_first,
    output logic o_pending
);
    localparam int DEPTH = LAT - 1;

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_first;
    logic             w_pending;

    // shift tags one stage per cycle, clear on flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_first <= '0;
        end else if (i_flush) begin
            r_valid <= '0;
            r_first <= '0;
        end else begin
            r_valid[0] <= i_valid;
            r_first[0] <= i_valid & i_first;
            for (int k = 1; k < DEPTH; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_first[k] <= r_first[k-1];
            end
        end
    end

    // tags still upstream of the tail (empty for LAT=2)
    always_comb begin
        w_pending = 1'b0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            w_pending = w_pending | r_valid[k];
        end
    end

    assign o_tail_valid = r_valid[DEPTH-1];
    assign o_tail_first = r_first[DEPTH-1];
    assign o_pending    = w_pending;

endmodule

// File: rtl/dsp_mac_sequencer.sv
// MAC run sequencer for a DSP48A1 slice: counts operand accepts, aligns
// OPMODE/CEP with the P stage, and reports completion.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for start; len==0 clears P and skips to ST_DONE
// ST_RUN   | accepting operand pairs until remaining reaches 0
// ST_DRAIN | no more accepts; waiting for in-flight tags to write P
// ST_DONE  | P holds the final sum; done pulses for one cycle
module dsp_mac_sequencer
    import dsp_mac_sequencer_pkg::*;
#(
    parameter int LAT   = 4,
    parameter int LEN_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dsp_mac_sequencer_if.slave   bus
);
    state_t           r_state;
    state_t           w_next;
    logic [LEN_W-1:0] r_remaining;
    logic [LEN_W-1:0] r_count;
    logic             w_abort;
    logic             w_ready;
    logic             w_accept;
    logic             w_rstp;
    logic             w_cep;
    logic             w_tail_valid;
    logic             w_tail_first;
    logic             w_pending;

    assign w_abort  = bus.abort && (r_state != ST_IDLE);
    // abort also closes the door so an abort cycle can never count as an accept
    assign w_ready  = (r_state == ST_RUN) && (r_remaining != '0) && !bus.abort;
    assign w_accept = w_ready && bus.s_valid;
    assign w_cep    = w_tail_valid && !w_abort;

    dsp_tag_pipe #(.LAT(LAT)) u_tag_pipe (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_flush      (w_abort),
        .i_valid      (w_accept),
        .i_first      (r_count == '0),
        .o_tail_valid (w_tail_valid),
        .o_tail_first (w_tail_first),
        .o_pending    (w_pending)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // next-state and P clear; abort overrides every other transition
    always_comb begin
        w_next = r_state;
        w_rstp = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.len != '0) begin
                        w_next = ST_RUN;
                    end else begin
                        // rstp comes straight off start here, so hold it low in reset
                        w_rstp = rst_n;
                        w_next = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (w_accept && (r_remaining == LEN_W'(1))) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!w_pending) w_next = ST_DONE;
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        if (w_abort) begin
            w_next = ST_IDLE;
            w_rstp = 1'b1;
        end
    end

    // remaining/accepted counters: loaded on start, stepped on each accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_remaining <= '0;
            r_count     <= '0;
        end else if ((r_state == ST_IDLE) && bus.start && (bus.len != '0)) begin
            r_remaining <= bus.len;
            r_count     <= '0;
        end else if (w_accept) begin
            r_remaining <= r_remaining - LEN_W'(1);
            r_count     <= r_count + LEN_W'(1);
        end
    end

    assign bus.s_ready = w_ready;
    assign bus.cep     = w_cep;
    assign bus.opmode  = w_cep ? (w_tail_first ? OPM_LOAD : OPM_ACC) : OPM_IDLE;
    assign bus.rstp    = w_rstp;
    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.done    = (r_state == ST_DONE) && !bus.abort;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Randomized scoreboard bench for dsp_mac_sequencer. The reference model
// predicts, per run, which cycles must show rstp, cep (with OPMODE) and done.
module tb_dsp_mac_sequencer;
    localparam int TB_LAT = 4;
    localparam int K_RSTP = 0;
    localparam int K_CEP  = 1;
    localparam int K_DONE = 2;

    typedef struct {
        int kind;
        int opm;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    ev_t  q[$];

    dsp_mac_sequencer_if #(.LEN_W(8)) bus ();

    dsp_mac_sequencer #(.LAT(TB_LAT), .LEN_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm, input int act, input int exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic push(input int kind, input int opm, input int c);
        ev_t e;
        e.kind = kind;
        e.opm  = opm;
        e.cyc  = c;
        q.push_back(e);
    endtask

    task automatic drop_from(input int c);
        while (q.size() > 0 && q[$].cyc >= c) void'(q.pop_back());
    endtask

    // monitor: every rstp/cep/done the DUT shows must be the next expected event
    always @(negedge clk) begin
        if (rst_n) begin
            int  k;
            ev_t e;
            if (!bus.cep) chk(bus.opmode == 8'h00, "opmode_idle", int'(bus.opmode), 0);
            if (bus.rstp || bus.cep || bus.done) begin
                k = bus.rstp ? K_RSTP : (bus.cep ? K_CEP : K_DONE);
                n_chk++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_event: got kind %0d opmode %0h at cycle %0d, expected none",
                             k, bus.opmode, cyc);
                end else begin
                    e = q.pop_front();
                    if (k == e.kind && (k != K_CEP || int'(bus.opmode) == e.opm) && cyc == e.cyc)
                        n_pass++;
                    else
                        $display("FAIL event: got kind %0d opmode %0h cycle %0d, expected kind %0d opmode %0h cycle %0d",
                                 k, bus.opmode, cyc, e.kind, e.opm, e.cyc);
                end
            end
        end
    end

    // one run: vmode 0=always valid, 1=pattern 1,0,1,1,0,1, 2=random, 3=two valids only
    task automatic do_run(input int n, input int vmode, input int ab_after, input int ab_dly, input bit poke);
        int         acc, t0, last, idx, ab_cyc, guard;
        bit         fin, aborted, v;
        logic [5:0] pat;
        pat = 6'b101101;
        chk(q.size() == 0, "queue_leftover", q.size(), 0);
        q.delete();
        @(posedge clk); #1;
        t0 = cyc;
        bus.start = 1'b1;
        bus.len   = 8'(n);
        acc = 0; idx = 0; ab_cyc = -1; last = t0 + 1; aborted = 0; guard = 0;
        fin = (n == 0);
        if (n == 0) begin
            push(K_RSTP, 0, t0);
            push(K_DONE, 0, t0 + 1);
        end
        @(negedge clk);
        chk(bus.busy == 1'b0 && bus.s_ready == 1'b0, "idle_at_start", int'(bus.busy), 0);
        while (!fin && guard < 300) begin
            @(posedge clk); #1;
            guard++;
            bus.start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.len   = 8'($urandom_range(0, 255));
            case (vmode)
                0:       v = 1'b1;
                1:       v = (idx < 6) ? pat[idx] : 1'b1;
                3:       v = (idx < 2);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.s_valid = v;
            idx++;
            if (cyc == ab_cyc) begin
                bus.abort = 1'b1;
                drop_from(cyc);
                push(K_RSTP, 0, cyc);
                aborted = 1;
                fin = 1;
            end
            @(negedge clk);
            if (!aborted) begin
                chk(bus.s_ready == (acc < n), "s_ready", int'(bus.s_ready), int'(acc < n));
                if (v && acc < n) begin
                    push(K_CEP, (acc == 0) ? 8'h01 : 8'h09, cyc + TB_LAT - 1);
                    acc++;
                    if (acc == ab_after) ab_cyc = cyc + ab_dly;
                    if (acc == n) begin
                        push(K_DONE, 0, cyc + TB_LAT);
                        last = cyc + TB_LAT;
                        fin = 1;
                    end
                end
            end
        end
        @(posedge clk); #1;
        bus.start = 1'b0; bus.s_valid = 1'b0; bus.abort = 1'b0; bus.len = '0;
        @(negedge clk);
        if (aborted) begin
            chk(bus.busy == 1'b0, "idle_after_abort", int'(bus.busy), 0);
            repeat (TB_LAT + 1) @(negedge clk);
        end else begin
            while (cyc < last + 1) @(negedge clk);
            chk(bus.busy == 1'b0 && bus.done == 1'b0, "idle_after_done", int'(bus.busy), 0);
        end
        chk(q.size() == 0, "events_outstanding", q.size(), 0);
        q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, n, ab, dly;
        rst_n = 1'b0;
        bus.start = 1'b1; bus.len = '0; bus.abort = 1'b0; bus.s_valid = 1'b0;
        #3;
        chk(bus.rstp == 1'b0,    "reset_rstp",    int'(bus.rstp), 0);
        chk(bus.busy == 1'b0,    "reset_busy",    int'(bus.busy), 0);
        chk(bus.s_ready == 1'b0, "reset_s_ready", int'(bus.s_ready), 0);
        chk(bus.cep == 1'b0,     "reset_cep",     int'(bus.cep), 0);
        chk(bus.opmode == 8'h00, "reset_opmode",  int'(bus.opmode), 0);
        chk(bus.done == 1'b0,    "reset_done",    int'(bus.done), 0);
        bus.start = 1'b0;
        #19;
        rst_n = 1'b1;
        @(negedge clk);
        chk(bus.busy == 1'b0, "first_idle", int'(bus.busy), 0);

        do_run(3, 0, 0, 0, 0);   // basic len=3 timing
        do_run(4, 1, 0, 0, 0);   // bubbles
        do_run(0, 0, 0, 0, 0);   // zero-length run
        do_run(5, 3, 2, 2, 0);   // abort two cycles after second accept
        do_run(2, 0, 1, 1, 0);   // abort coincides with final accept
        do_run(4, 2, 0, 0, 1);   // start/len wiggled while busy

        // asynchronous reset in DRAIN, then a fresh 2-sample run
        @(posedge clk); #1;
        t0 = cyc;
        bus.start = 1'b1; bus.len = 8'd2;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.s_valid = 1'b1;
        push(K_CEP, 8'h01, t0 + 1 + TB_LAT - 1);
        @(posedge clk); #1;
        push(K_CEP, 8'h09, t0 + 2 + TB_LAT - 1);
        push(K_DONE, 0, t0 + 2 + TB_LAT);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        @(posedge clk); #2;
        chk(bus.busy == 1'b1 && bus.cep == 1'b1, "pre_reset_drain", int'(bus.cep), 1);
        #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk(bus.busy == 1'b0,    "async_busy",    int'(bus.busy), 0);
        chk(bus.cep == 1'b0,     "async_cep",     int'(bus.cep), 0);
        chk(bus.opmode == 8'h00, "async_opmode",  int'(bus.opmode), 0);
        chk(bus.s_ready == 1'b0, "async_s_ready", int'(bus.s_ready), 0);
        chk(bus.rstp == 1'b0,    "async_rstp",    int'(bus.rstp), 0);
        chk(bus.done == 1'b0,    "async_done",    int'(bus.done), 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        chk(bus.busy == 1'b0, "idle_after_reset", int'(bus.busy), 0);
        do_run(2, 0, 0, 0, 0);

        for (int r = 0; r < 20; r++) begin
            n   = $urandom_range(0, 9);
            ab  = 0;
            dly = 0;
            if (n > 1 && $urandom_range(0, 3) == 0) begin
                ab  = $urandom_range(1, n - 1);
                dly = $urandom_range(1, 3);
            end
            do_run(n, 2, ab, dly, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
